// File: rtl/bl_spi_serializer24_if.sv
`default_nettype none
// ============================================================================
// Module      : bl_spi_serializer24_if
// Description : Frame-data and serial-link bundle for bl_spi_serializer24.
//               The master side supplies the frame flag and block word; the
//               slave side drives the SCLK/SDO/LATCH link and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface bl_spi_serializer24_if;
    logic         iV_Duty;
    logic [191:0] iBlockData;
    logic         oSCLK;
    logic         oSDO;
    logic         oLATCH;
    logic         oBusy;
    logic         oFrameDrop;

    modport master (
        output iV_Duty, iBlockData,
        input  oSCLK, oSDO, oLATCH, oBusy, oFrameDrop
    );

    modport slave (
        input  iV_Duty, iBlockData,
        output oSCLK, oSDO, oLATCH, oBusy, oFrameDrop
    );
endinterface
`default_nettype wire

// File: rtl/bl_spi_serializer24.sv
`default_nettype none
// ============================================================================
// Module      : bl_spi_serializer24
// Description : Double-buffered serializer for the 24 x 8-bit block-luminance
//               word. Captures a frame on the iV_Duty falling edge and shifts
//               it out MSB-first, block 0 first, over SCLK/SDO, then strobes
//               LATCH. Newer frames overwrite unsent ones (oFrameDrop).
//               Define BL_SPI_CHECKSUM_EN to append an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module bl_spi_serializer24 #(
    parameter int CLK_DIV = 4,   // SCLK half-period in iODCK cycles (1..255)
    parameter int LATCH_W = 2    // LATCH width in SCLK periods (1..15)
) (
    input  wire logic             iODCK,
    input  wire logic             iRST,
    bl_spi_serializer24_if.slave  bus
);

`ifdef BL_SPI_CHECKSUM_EN
    localparam int c_NBITS = 200;
`else
    localparam int c_NBITS = 192;
`endif
    localparam int         c_NBLK      = 24;
    localparam logic [7:0] c_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_BIT_LAST  = 8'(c_NBITS - 1);
    // LATCH is timed in SCLK half-periods on top of divcnt, keeping the
    // counter small for every legal CLK_DIV/LATCH_W combination.
    localparam logic [11:0] c_HALF_LAST = 12'(2 * LATCH_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_vd_q;
    logic               r_pending;
    logic [191:0]       r_shadow;
    logic [c_NBITS-2:0] r_sr;        // bits still to send after the current one
    logic [7:0]         r_bitcnt;
    logic [7:0]         r_divcnt;
    logic [11:0]        r_lcnt;
    logic               r_sclk;
    logic               r_sdo;
    logic               r_latch;
    logic               r_busy;
    logic               r_drop;

    logic               w_cap;
    logic [c_NBITS-1:0] w_ordered;

    assign w_cap = r_vd_q & ~bus.iV_Duty;

    // Wire order: block 0 occupies the top byte so it leaves first, MSB first.
    generate
        for (genvar n = 0; n < c_NBLK; n++) begin : g_order
            assign w_ordered[c_NBITS-1-8*n -: 8] = r_shadow[8*n +: 8];
        end
    endgenerate

`ifdef BL_SPI_CHECKSUM_EN
    logic [7:0] w_csum;

    // XOR of all block bytes, appended after block 23.
    always_comb begin
        w_csum = 8'h00;
        for (int n = 0; n < c_NBLK; n++) begin
            w_csum = w_csum ^ r_shadow[8*n +: 8];
        end
    end

    assign w_ordered[7:0] = w_csum;
`endif

    // Frame capture, shadow/pending bookkeeping and the transmit state machine.
    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            r_state   <= S_IDLE;
            r_vd_q    <= 1'b0;
            r_pending <= 1'b0;
            r_shadow  <= '0;
            r_sr      <= '0;
            r_bitcnt  <= '0;
            r_divcnt  <= '0;
            r_lcnt    <= '0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_vd_q <= bus.iV_Duty;
            r_drop <= 1'b0;

            // A capture always wins over LOAD consuming the pending frame.
            if (w_cap) begin
                r_shadow  <= bus.iBlockData;
                r_pending <= 1'b1;
                if (r_pending && (r_state != S_LOAD)) begin
                    r_drop <= 1'b1;
                end
            end else if (r_state == S_LOAD) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_sr     <= w_ordered[c_NBITS-2:0];
                    r_sdo    <= w_ordered[c_NBITS-1];
                    r_bitcnt <= '0;
                    r_divcnt <= '0;
                    r_sclk   <= 1'b0;
                    r_busy   <= 1'b1;
                    r_state  <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (r_divcnt == c_DIV_LAST) begin
                        r_divcnt <= '0;
                        r_sclk   <= ~r_sclk;
                        // Data advances only on the falling SCLK toggle.
                        if (r_sclk) begin
                            r_bitcnt <= r_bitcnt + 8'd1;
                            if (r_bitcnt == c_BIT_LAST) begin
                                r_sdo   <= 1'b0;
                                r_latch <= 1'b1;
                                r_lcnt  <= '0;
                                r_state <= S_LATCH;
                            end else begin
                                r_sdo <= r_sr[c_NBITS-2];
                                r_sr  <= {r_sr[c_NBITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        r_divcnt <= r_divcnt + 8'd1;
                    end
                end

                S_LATCH: begin
                    if (r_divcnt == c_DIV_LAST) begin
                        r_divcnt <= '0;
                        if (r_lcnt == c_HALF_LAST) begin
                            r_latch <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_lcnt <= r_lcnt + 12'd1;
                        end
                    end else begin
                        r_divcnt <= r_divcnt + 8'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.oSCLK      = r_sclk;
    assign bus.oSDO       = r_sdo;
    assign bus.oLATCH     = r_latch;
    assign bus.oBusy      = r_busy;
    assign bus.oFrameDrop = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_bl_spi_serializer24.sv
`default_nettype none
// ============================================================================
// Module      : tb_bl_spi_serializer24
// Description : Self-checking bench for bl_spi_serializer24. Two instances
//               (default timing and CLK_DIV=1/LATCH_W=1) are observed by a
//               wire-level monitor that decodes each latched frame; decoded
//               frames are compared with a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bl_spi_serializer24;
    localparam int CD0 = 4;
    localparam int LW0 = 2;
    localparam int CD1 = 1;
    localparam int LW1 = 1;
`ifdef BL_SPI_CHECKSUM_EN
    localparam int NB = 200;
`else
    localparam int NB = 192;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bl_spi_serializer24_if bus0 ();
    bl_spi_serializer24_if bus1 ();

    bl_spi_serializer24 #(.CLK_DIV(CD0), .LATCH_W(LW0)) dut0 (
        .iODCK (clk),
        .iRST  (rst_n),
        .bus   (bus0)
    );

    bl_spi_serializer24 #(.CLK_DIV(CD1), .LATCH_W(LW1)) dut1 (
        .iODCK (clk),
        .iRST  (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        int           nb;
        logic [199:0] bits;
        int           lat;
        int           busy;
        int           gap;
        int           lead;
    } frame_t;

    typedef struct {
        logic [191:0] data;
        logic [7:0]   first;
        logic [7:0]   last;
        logic [7:0]   csum;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    frame_t fq0[$];
    frame_t fq1[$];

    logic [1:0] m_sclk, m_sdo, m_lat, m_busy, m_drop;
    assign m_sclk = {bus1.oSCLK,      bus0.oSCLK};
    assign m_sdo  = {bus1.oSDO,       bus0.oSDO};
    assign m_lat  = {bus1.oLATCH,     bus0.oLATCH};
    assign m_busy = {bus1.oBusy,      bus0.oBusy};
    assign m_drop = {bus1.oFrameDrop, bus0.oFrameDrop};

    logic [1:0]   p_sclk, p_sdo, p_lat, p_busy;
    logic [199:0] mb_bits [2];
    int mb_n [2], m_latc [2], m_busyc [2], m_blen [2], m_low [2], m_gap [2];
    int m_brise [2], m_lead [2], m_last_rise [2], m_rises [2], m_latr [2];
    int m_drops [2], m_sdo_hi [2], m_per_bad [2];
    int m_cyc = 0;
    frame_t mf;

    function automatic int cd_of(input int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    function automatic int lw_of(input int i);
        return (i == 0) ? LW0 : LW1;
    endfunction

    // Reference: byte k on the wire is block k; byte 24 is the XOR of all blocks.
    function automatic logic [7:0] exp_byte(input logic [191:0] d, input int k);
        logic [7:0] x;
        x = 8'h00;
        if (k < 24) return d[8*k +: 8];
        for (int n = 0; n < 24; n++) x = x ^ d[8*n +: 8];
        return x;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Wire-level monitor: samples on the falling clock edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            mb_bits[i] = '0; mb_n[i] = 0; m_latc[i] = 0; m_busyc[i] = 0; m_blen[i] = 0;
            m_low[i] = 0; m_gap[i] = 0; m_brise[i] = 0; m_lead[i] = 0; m_last_rise[i] = 0;
            m_rises[i] = 0; m_latr[i] = 0; m_drops[i] = 0; m_sdo_hi[i] = 0; m_per_bad[i] = 0;
        end
        p_sclk = '0; p_sdo = '0; p_lat = '0; p_busy = '0;
        forever begin
            @(negedge clk);
            m_cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    p_sclk[i] = 1'b0; p_sdo[i] = 1'b0; p_lat[i] = 1'b0; p_busy[i] = 1'b0;
                    mb_n[i] = 0; m_latc[i] = 0; m_busyc[i] = 0; m_low[i] = 0;
                end else begin
                    if (m_drop[i]) m_drops[i]++;
                    if (p_sclk[i] && m_sclk[i] && (m_sdo[i] != p_sdo[i])) m_sdo_hi[i]++;
                    if (!p_sclk[i] && m_sclk[i]) begin
                        if (mb_n[i] == 0) m_lead[i] = m_cyc - m_brise[i];
                        else if ((m_cyc - m_last_rise[i]) != 2 * cd_of(i)) m_per_bad[i]++;
                        m_last_rise[i] = m_cyc;
                        mb_bits[i] = {mb_bits[i][198:0], m_sdo[i]};
                        mb_n[i]++;
                    end
                    if (m_lat[i]) m_latc[i]++;
                    if (m_busy[i]) m_busyc[i]++;
                    else m_low[i]++;
                    if (!p_busy[i] && m_busy[i]) begin
                        m_gap[i] = m_low[i]; m_low[i] = 0; m_brise[i] = m_cyc; m_rises[i]++;
                    end
                    if (p_busy[i] && !m_busy[i]) begin
                        m_blen[i] = m_busyc[i]; m_busyc[i] = 0;
                    end
                    if (!p_lat[i] && m_lat[i]) m_latr[i]++;
                    if (p_lat[i] && !m_lat[i]) begin
                        mf.nb = mb_n[i]; mf.bits = mb_bits[i]; mf.lat = m_latc[i];
                        mf.busy = m_blen[i]; mf.gap = m_gap[i]; mf.lead = m_lead[i];
                        if (i == 0) fq0.push_back(mf);
                        else fq1.push_back(mf);
                        m_latc[i] = 0; mb_n[i] = 0;
                    end
                    p_sclk[i] = m_sclk[i]; p_sdo[i] = m_sdo[i];
                    p_lat[i] = m_lat[i]; p_busy[i] = m_busy[i];
                end
            end
        end
    end

    // One iV_Duty falling edge; lat = clock edges until oBusy of instance 0 rises.
    task automatic send(input logic [191:0] d0, input logic [191:0] d1, input bit use1, output int lat);
        @(posedge clk); #1;
        bus0.iBlockData = d0; bus0.iV_Duty = 1'b0;
        if (use1) begin bus1.iBlockData = d1; bus1.iV_Duty = 1'b0; end
        lat = -1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin bus0.iV_Duty = 1'b1; bus1.iV_Duty = 1'b1; end
            if (lat < 0 && bus0.oBusy) lat = k;
        end
    endtask

    task automatic wait_q(input int n0, input int n1, input string nm);
        int t;
        t = 0;
        while ((fq0.size() < n0 || fq1.size() < n1) && t < 6000) begin
            @(posedge clk); t++;
        end
        chk({nm, ".frames_done"}, longint'(fq0.size() >= n0 && fq1.size() >= n1), 1);
    endtask

    task automatic check_frame(input int inst, input logic [191:0] d, input string nm,
                               input int exp_gap, output frame_t f);
        int bad, cd, lw;
        f = '{nb: 0, bits: '0, lat: 0, busy: 0, gap: 0, lead: 0};
        if ((inst == 0 && fq0.size() == 0) || (inst == 1 && fq1.size() == 0)) begin
            chk({nm, ".present"}, 0, 1);
            return;
        end
        if (inst == 0) f = fq0.pop_front();
        else f = fq1.pop_front();
        cd = cd_of(inst);
        lw = lw_of(inst);
        chk({nm, ".sclk_edges"}, f.nb, NB);
        chk({nm, ".first_sclk_lead"}, f.lead, 1 + cd);
        chk({nm, ".latch_cycles"}, f.lat, lw * 2 * cd);
        chk({nm, ".busy_cycles"}, f.busy, 1 + NB * 2 * cd + lw * 2 * cd);
        if (exp_gap >= 0) chk({nm, ".idle_gap"}, f.gap, exp_gap);
        bad = NB / 8;
        if (f.nb == NB) begin
            bad = 0;
            for (int k = 0; k < NB / 8; k++) begin
                if (f.bits[NB-1-8*k -: 8] !== exp_byte(d, k)) bad++;
            end
        end
        chk({nm, ".bad_bytes"}, bad, 0);
    endtask

    vec_t         tbl [5];
    frame_t       fr;
    int           lat, d_b, r_b, l_b;
    logic [191:0] d, fa, fb, fc;
    logic [7:0]   b;

    initial begin
        bus0.iV_Duty = 1'b1; bus0.iBlockData = '0;
        bus1.iV_Duty = 1'b1; bus1.iBlockData = '0;

        // Vector table: data pattern with hand-derived first/last/checksum bytes.
        for (int n = 0; n < 24; n++) d[8*n +: 8] = 8'(n + 1);
        tbl[0] = '{data: d, first: 8'h01, last: 8'h18, csum: 8'h18};
        for (int n = 0; n < 24; n++) d[8*n +: 8] = 8'hA5;
        tbl[1] = '{data: d, first: 8'hA5, last: 8'hA5, csum: 8'h00};
        tbl[2] = '{data: '0, first: 8'h00, last: 8'h00, csum: 8'h00};
        for (int n = 0; n < 24; n++) d[8*n +: 8] = (n % 2 == 1) ? 8'hFF : 8'h00;
        tbl[3] = '{data: d, first: 8'h00, last: 8'hFF, csum: 8'h00};
        b = 8'h80;
        for (int n = 0; n < 24; n++) d[8*n +: 8] = b >> (n % 8);
        tbl[4] = '{data: d, first: 8'h80, last: 8'h01, csum: 8'hFF};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outs0", {m_sclk[0], m_sdo[0], m_lat[0], m_busy[0], m_drop[0]}, 0);
        chk("reset.outs1", {m_sclk[1], m_sdo[1], m_lat[1], m_busy[1], m_drop[1]}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Table-driven frames on both instances.
        for (int v = 0; v < 5; v++) begin
            send(tbl[v].data, tbl[v].data, 1'b1, lat);
            chk($sformatf("tbl%0d.busy_latency", v), lat, 2);
            wait_q(1, 1, $sformatf("tbl%0d", v));
            check_frame(0, tbl[v].data, $sformatf("tbl%0d.i0", v), -1, fr);
            chk($sformatf("tbl%0d.first_byte", v), fr.bits[NB-1 -: 8], tbl[v].first);
            chk($sformatf("tbl%0d.block23", v), fr.bits[NB-185 -: 8], tbl[v].last);
`ifdef BL_SPI_CHECKSUM_EN
            chk($sformatf("tbl%0d.checksum", v), fr.bits[7:0], tbl[v].csum);
`endif
            check_frame(1, tbl[v].data, $sformatf("tbl%0d.i1", v), -1, fr);
            repeat (3) @(posedge clk);
        end

        // Randomized frames against the byte-level model.
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 6; w++) begin
                fa[32*w +: 32] = $urandom;
                fb[32*w +: 32] = $urandom;
            end
            send(fa, fb, 1'b1, lat);
            chk($sformatf("rnd%0d.busy_latency", r), lat, 2);
            wait_q(1, 1, $sformatf("rnd%0d", r));
            check_frame(0, fa, $sformatf("rnd%0d.i0", r), -1, fr);
            check_frame(1, fb, $sformatf("rnd%0d.i1", r), -1, fr);
            repeat ($urandom_range(1, 40)) @(posedge clk);
        end

        // Three frames 300 cycles apart: middle one is overwritten.
        for (int w = 0; w < 6; w++) begin
            fa[32*w +: 32] = $urandom;
            fb[32*w +: 32] = $urandom;
            fc[32*w +: 32] = $urandom;
        end
        d_b = m_drops[0];
        send(fa, '0, 1'b0, lat);
        repeat (295) @(posedge clk);
        send(fb, '0, 1'b0, lat);
        repeat (295) @(posedge clk);
        send(fc, '0, 1'b0, lat);
        wait_q(2, 0, "drop");
        check_frame(0, fa, "drop.F1", -1, fr);
        check_frame(0, fc, "drop.F3", 1, fr);
        chk("drop.pulses", m_drops[0] - d_b, 1);
        repeat (2000) @(posedge clk);
        chk("drop.extra_frames", fq0.size(), 0);

        // Capture coincides with LOAD: old shadow goes out, new one follows.
        for (int w = 0; w < 6; w++) begin
            fa[32*w +: 32] = $urandom;
            fb[32*w +: 32] = $urandom;
        end
        d_b = m_drops[0];
        @(posedge clk); #1;
        bus0.iBlockData = fa; bus0.iV_Duty = 1'b0;
        @(posedge clk); #1;
        bus0.iV_Duty = 1'b1;
        @(posedge clk); #1;
        bus0.iBlockData = fb; bus0.iV_Duty = 1'b0;
        @(posedge clk); #1;
        bus0.iV_Duty = 1'b1;
        wait_q(2, 0, "coinc");
        check_frame(0, fa, "coinc.old", -1, fr);
        check_frame(0, fb, "coinc.new", 1, fr);
        chk("coinc.drop_pulses", m_drops[0] - d_b, 0);

        // Asynchronous reset in the middle of a transfer.
        for (int w = 0; w < 6; w++) fa[32*w +: 32] = $urandom;
        send(fa, '0, 1'b0, lat);
        for (int t = 0; t < 3000 && mb_n[0] < 100; t++) begin
            @(posedge clk); #1;
        end
        chk("rst.reached_bit100", longint'(mb_n[0] >= 100), 1);
        #2;
        rst_n = 1'b0;
        bus0.iV_Duty = 1'b0;
        bus1.iV_Duty = 1'b0;
        #1;
        chk("rst.async_outs0", {m_sclk[0], m_sdo[0], m_lat[0], m_busy[0], m_drop[0]}, 0);
        r_b = m_rises[0];
        l_b = m_latr[0];
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        chk("rst.no_restart", m_rises[0] - r_b, 0);
        chk("rst.no_latch", m_latr[0] - l_b, 0);
        chk("rst.no_frame", fq0.size(), 0);
        chk("rst.idle_outs0", {m_sclk[0], m_sdo[0], m_lat[0], m_busy[0], m_drop[0]}, 0);
        chk("rst.idle_outs1", {m_sclk[1], m_sdo[1], m_lat[1], m_busy[1], m_drop[1]}, 0);

        // Link-level properties accumulated over the whole run.
        chk("sdo_change_while_sclk_high.i0", m_sdo_hi[0], 0);
        chk("sdo_change_while_sclk_high.i1", m_sdo_hi[1], 0);
        chk("sclk_period.i0", m_per_bad[0], 0);
        chk("sclk_period.i1", m_per_bad[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
